pin_entry_checker: RTL and testbench
====================================

Name: pin_entry_checker

Overview:
- Upstream PIN front end for the ATM session controller.
- Collects BCD keypad digits while a card is present, compares them with the card's stored PIN, and allows a limited number of attempts.
- Drives a registered `pin_ok` level that feeds the session controller's PIN input.
- Retains the card after repeated failures and abandons an idle entry after a timeout.

Parameters:
- DIGITS, 4, number of PIN digits (1..8).
- MAX_TRIES, 3, wrong attempts allowed before the card is retained (1..7).
- TIMEOUT_CYCLES, 1000, idle cycles in COLLECT before the session is abandoned (>=2).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- card  in  1  card-present level.
- stored_pin  in  4*DIGITS  stored PIN as BCD; the first digit entered is compared with the most-significant nibble.
- digit_valid  in  1  one-cycle strobe qualifying `digit`.
- digit  in  4  BCD keypad value.
- enter  in  1  one-cycle strobe: submit the entry.
- cancel  in  1  one-cycle strobe: abort the session.
- pin_ok  out  1  level: PIN verified; held while in AUTH.
- pin_fail  out  1  one-cycle pulse per wrong submission.
- card_retain  out  1  level: attempt limit reached.
- tries_left  out  3  remaining attempts.
- digits_entered  out  4  digits currently buffered.

Behaviour:
- Reset: `reset`=0 sampled at a rising edge of `clock` (synchronous, active-low).
  - state=IDLE; pin_ok=0, pin_fail=0, card_retain=0, digits_entered=0.
  - tries_left=MAX_TRIES; entry buffer and timeout counter cleared.
  - Reset overrides every other input, in every state, including mid-entry and RETAIN.
- All outputs are registered; there is no combinational path from inputs to outputs.
- States: IDLE, COLLECT, CHECK, AUTH, RETAIN.
- Input priority within one cycle: card==0 > cancel > enter > digit_valid. A lower-priority event in the same cycle is dropped.
- IDLE:
  - card==1 -> COLLECT; tries_left=MAX_TRIES, digits_entered=0, timeout counter=0.
- COLLECT:
  - digit_valid, digit<=9 and digits_entered<DIGITS: digit shifts into the buffer, digits_entered+1, timeout counter cleared.
  - digit_valid with digit>9, or with the buffer full: ignored; does not clear the timeout counter.
  - enter with digits_entered==DIGITS -> CHECK.
  - enter with fewer digits: ignored; no attempt is consumed.
  - cancel or card==0 -> IDLE; buffer cleared.
  - Timeout counter increments every cycle otherwise; reaching TIMEOUT_CYCLES-1 -> IDLE, buffer cleared.
- CHECK (exactly one cycle; inputs ignored):
  - Buffer == stored_pin -> AUTH, pin_ok=1.
  - Mismatch: pin_fail=1 for one cycle, tries_left-1, digits_entered=0.
    - New tries_left==0 -> RETAIN.
    - Otherwise -> COLLECT.
- Latency: enter sampled at edge k -> CHECK after k -> pin_ok or pin_fail visible after edge k+1.
- AUTH:
  - pin_ok held at 1.
  - card==0 or cancel -> IDLE; pin_ok=0 after that edge.
  - digit_valid and enter are ignored.
- RETAIN:
  - card_retain=1, pin_ok=0.
  - All inputs, including card==0, are ignored; exit only by reset.
- stored_pin is sampled only in CHECK; changing it at other times has no effect.
- tries_left never underflows; it is only decremented in CHECK, where it is >=1.

Decomposition:
- Shared package atm_pkg holds:
  - PIN state encodings (IDLE=0, COLLECT=1, CHECK=2, AUTH=3, RETAIN=4; 3-bit);
  - BCD_MAX=9;
  - the existing amount codes (FIFTY=01, HUNDRED=10, TWO_HUNDRED=11);
  - the session-controller state encodings, so both stages share one definition.
- One sub-module: pin_digit_buffer.
  - Contains the shift register, digits_entered counter, and full flag.
  - Controls: clear, shift, digit in.
  - Outputs: buffer, count, full.
- The FSM, attempt counter and timeout counter stay in pin_entry_checker.

Test Plan:
- Correct PIN: stored_pin=16'h1234, card=1, digits 1,2,3,4, enter at edge k -> pin_ok=1 after edge k+1, pin_fail never asserted, tries_left=3; card=0 -> pin_ok=0 next edge.
- Wrong then correct: enter 1,2,3,5 -> single-cycle pin_fail, tries_left=2, digits_entered=0; then enter 1,2,3,4 -> pin_ok=1, tries_left=2.
- Lockout: three wrong entries -> card_retain=1 after the third CHECK, tries_left=0.
  - Further digits, enter, cancel and card=0 change nothing.
  - reset=0 for one edge -> all outputs return to reset values.
- Input filtering:
  - digit 4'hA -> ignored (digits_entered unchanged).
  - enter after 3 digits -> ignored, tries_left unchanged.
  - 5th digit -> ignored.
  - enter together with digit_valid -> enter wins.
- Timeout/cancel (TIMEOUT_CYCLES=16): 2 digits then 16 idle cycles -> state IDLE, digits_entered=0.
  - Re-insert card -> tries_left=3.
  - cancel mid-entry -> IDLE next edge.
- Reset mid-operation: reset=0 while in CHECK and while in AUTH -> pin_ok=0, pin_fail=0, state IDLE after that edge.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared ATM definitions: PIN-stage and session-controller encodings, amount codes.
package atm_pkg;

    // PIN entry stage states
    typedef enum logic [2:0] {
        PIN_IDLE    = 3'd0,
        PIN_COLLECT = 3'd1,
        PIN_CHECK   = 3'd2,
        PIN_AUTH    = 3'd3,
        PIN_RETAIN  = 3'd4
    } pin_state_t;

    // Largest legal BCD keypad value
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Withdrawal amount codes
    typedef enum logic [1:0] {
        AMT_NONE    = 2'b00,
        FIFTY       = 2'b01,
        HUNDRED     = 2'b10,
        TWO_HUNDRED = 2'b11
    } amount_t;

    // Session controller states, downstream of the PIN stage
    typedef enum logic [2:0] {
        SES_IDLE     = 3'd0,
        SES_WAIT_PIN = 3'd1,
        SES_SELECT   = 3'd2,
        SES_DISPENSE = 3'd3,
        SES_EJECT    = 3'd4
    } session_state_t;

    // True when a keypad nibble is a valid decimal digit
    function automatic logic is_bcd(input logic [3:0] value);
        return value <= BCD_MAX;
    endfunction

endpackage

// File: rtl/pin_digit_buffer.sv
// Shift register holding the digits typed so far, first digit ends up most significant.
module pin_digit_buffer
    import atm_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  shift,
    input  logic [3:0]            digit,
    output logic [4*DIGITS-1:0]   buffer,
    output logic [3:0]            count,
    output logic                  full
);

    localparam int unsigned BW = 4 * DIGITS;

    // Clear wins over shift; a shift into a full buffer is dropped
    always_ff @(posedge clock) begin
        if (!reset) begin
            buffer <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else if (clear) begin
            buffer <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else if (shift && !full) begin
            buffer <= (buffer << 4) | BW'(digit);
            count  <= count + 4'd1;
            full   <= (count == 4'(DIGITS - 1));
        end
    end

endmodule

// File: rtl/pin_entry_checker.sv
// PIN front end: collects keypad digits, verifies against the card PIN, limits attempts.
module pin_entry_checker
    import atm_pkg::*;
#(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  card,
    input  logic [4*DIGITS-1:0]   stored_pin,
    input  logic                  digit_valid,
    input  logic [3:0]            digit,
    input  logic                  enter,
    input  logic                  cancel,
    output logic                  pin_ok,
    output logic                  pin_fail,
    output logic                  card_retain,
    output logic [2:0]            tries_left,
    output logic [3:0]            digits_entered
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    pin_state_t            state;
    logic [TW-1:0]         timeout_cnt;
    logic [4*DIGITS-1:0]   buffer;
    logic                  full;

    logic in_collect_c;
    logic abort_c;
    logic submit_c;
    logic shift_c;
    logic timeout_c;
    logic match_c;
    logic leave_auth_c;
    logic clear_c;

    pin_digit_buffer #(
        .DIGITS (DIGITS)
    ) u_buffer (
        .clock  (clock),
        .reset  (reset),
        .clear  (clear_c),
        .shift  (shift_c),
        .digit  (digit),
        .buffer (buffer),
        .count  (digits_entered),
        .full   (full)
    );

    // Decode the single winning input event per cycle: card removal > cancel > enter > digit
    always_comb begin
        in_collect_c = (state == PIN_COLLECT);
        abort_c      = in_collect_c && (!card || cancel);
        submit_c     = in_collect_c && card && !cancel && enter && full;
        shift_c      = in_collect_c && card && !cancel && !enter
                       && digit_valid && is_bcd(digit) && !full;
        timeout_c    = in_collect_c && !abort_c && !submit_c && !shift_c
                       && (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));
        match_c      = (buffer == stored_pin);
        leave_auth_c = (state == PIN_AUTH) && (!card || cancel);
        clear_c      = ((state == PIN_IDLE) && card) || abort_c || timeout_c
                       || ((state == PIN_CHECK) && !match_c) || leave_auth_c;
    end

    // Session FSM with attempt and idle-timeout counters; all outputs registered
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= PIN_IDLE;
            pin_ok      <= 1'b0;
            pin_fail    <= 1'b0;
            card_retain <= 1'b0;
            tries_left  <= 3'(MAX_TRIES);
            timeout_cnt <= '0;
        end else begin
            pin_fail <= 1'b0;
            case (state)
                PIN_IDLE: begin
                    if (card) begin
                        state       <= PIN_COLLECT;
                        tries_left  <= 3'(MAX_TRIES);
                        timeout_cnt <= '0;
                    end
                end
                PIN_COLLECT: begin
                    if (abort_c || timeout_c) begin
                        state <= PIN_IDLE;
                    end else if (submit_c) begin
                        state <= PIN_CHECK;
                    end else if (shift_c) begin
                        timeout_cnt <= '0;
                    end else begin
                        timeout_cnt <= timeout_cnt + TW'(1);
                    end
                end
                PIN_CHECK: begin
                    if (match_c) begin
                        state  <= PIN_AUTH;
                        pin_ok <= 1'b1;
                    end else begin
                        pin_fail   <= 1'b1;
                        tries_left <= tries_left - 3'd1;
                        if (tries_left == 3'd1) begin
                            state       <= PIN_RETAIN;
                            card_retain <= 1'b1;
                        end else begin
                            state       <= PIN_COLLECT;
                            timeout_cnt <= '0;
                        end
                    end
                end
                PIN_AUTH: begin
                    if (leave_auth_c) begin
                        state  <= PIN_IDLE;
                        pin_ok <= 1'b0;
                    end
                end
                PIN_RETAIN: begin
                    card_retain <= 1'b1;
                    pin_ok      <= 1'b0;
                end
                default: begin
                    state  <= PIN_IDLE;
                    pin_ok <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pin_entry_checker.sv
// Self-checking bench for pin_entry_checker with a transaction-level reference model.
module tb_pin_entry_checker;

    localparam int unsigned DIGITS         = 4;
    localparam int unsigned MAX_TRIES      = 3;
    localparam int unsigned TIMEOUT_CYCLES = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        card;
    logic [15:0] stored_pin;
    logic        digit_valid;
    logic [3:0]  digit;
    logic        enter;
    logic        cancel;
    logic        pin_ok;
    logic        pin_fail;
    logic        card_retain;
    logic [2:0]  tries_left;
    logic [3:0]  digits_entered;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pin_entry_checker #(
        .DIGITS         (DIGITS),
        .MAX_TRIES      (MAX_TRIES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .card           (card),
        .stored_pin     (stored_pin),
        .digit_valid    (digit_valid),
        .digit          (digit),
        .enter          (enter),
        .cancel         (cancel),
        .pin_ok         (pin_ok),
        .pin_fail       (pin_fail),
        .card_retain    (card_retain),
        .tries_left     (tries_left),
        .digits_entered (digits_entered)
    );

    // Reference model: what the session looks like to a user at the keypad
    typedef enum {M_WAIT_CARD, M_ENTRY, M_VERIFY, M_GRANTED, M_LOCKED} phase_t;
    phase_t m_phase = M_WAIT_CARD;
    int     m_typed[$];
    int     m_tries = MAX_TRIES;
    int     m_idle  = 0;
    bit     m_ok    = 1'b0;
    bit     m_fail  = 1'b0;
    bit     m_retain = 1'b0;

    function automatic int typed_value();
        int v = 0;
        foreach (m_typed[i]) v = v * 16 + m_typed[i];
        return v;
    endfunction

    function automatic void model_step();
        m_fail = 1'b0;
        if (!reset) begin
            m_phase = M_WAIT_CARD; m_ok = 1'b0; m_retain = 1'b0;
            m_tries = MAX_TRIES; m_typed.delete(); m_idle = 0;
            return;
        end
        case (m_phase)
            M_WAIT_CARD: if (card) begin
                m_phase = M_ENTRY; m_tries = MAX_TRIES; m_typed.delete(); m_idle = 0;
            end
            M_ENTRY: begin
                if (!card || cancel) begin
                    m_phase = M_WAIT_CARD; m_typed.delete();
                end else if (enter && m_typed.size() == DIGITS) begin
                    m_phase = M_VERIFY;
                end else if (!enter && digit_valid && digit <= 4'd9 && m_typed.size() < DIGITS) begin
                    m_typed.push_back(int'(digit)); m_idle = 0;
                end else begin
                    m_idle++;
                    if (m_idle >= TIMEOUT_CYCLES) begin
                        m_phase = M_WAIT_CARD; m_typed.delete(); m_idle = 0;
                    end
                end
            end
            M_VERIFY: begin
                if (typed_value() == int'(stored_pin)) begin
                    m_phase = M_GRANTED; m_ok = 1'b1;
                end else begin
                    m_fail = 1'b1; m_tries--; m_typed.delete();
                    if (m_tries == 0) begin
                        m_phase = M_LOCKED; m_retain = 1'b1;
                    end else begin
                        m_phase = M_ENTRY; m_idle = 0;
                    end
                end
            end
            M_GRANTED: if (!card || cancel) begin
                m_phase = M_WAIT_CARD; m_ok = 1'b0; m_typed.delete();
            end
            default: ;
        endcase
    endfunction

    function automatic logic [9:0] model_vec();
        return {m_ok, m_fail, m_retain, 3'(m_tries), 4'(m_typed.size())};
    endfunction

    // One clock edge: model follows the same sampled inputs, outputs settle 1 time unit later
    task automatic step();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic press_digit(input logic [3:0] d);
        digit_valid = 1'b1; digit = d;
        step();
        digit_valid = 1'b0;
    endtask

    task automatic press_enter();
        enter = 1'b1;
        step();
        enter = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; card = 1'b0; digit_valid = 1'b0; digit = 4'd0;
        enter = 1'b0; cancel = 1'b0; stored_pin = 16'h1234;
        step(); step();
        reset = 1'b1;
        checks++; if (pin_ok !== 1'b0) begin errors++; $display("FAIL reset_pin_ok: got %0b expected 0", pin_ok); end
        checks++; if (pin_fail !== 1'b0) begin errors++; $display("FAIL reset_pin_fail: got %0b expected 0", pin_fail); end
        checks++; if (card_retain !== 1'b0) begin errors++; $display("FAIL reset_retain: got %0b expected 0", card_retain); end
        checks++; if (tries_left !== 3'd3) begin errors++; $display("FAIL reset_tries: got %0d expected 3", tries_left); end
        checks++; if (digits_entered !== 4'd0) begin errors++; $display("FAIL reset_digits: got %0d expected 0", digits_entered); end
    endtask

    task automatic test_correct_pin();
        logic fail_seen = 1'b0;
        card = 1'b1; step();
        for (int i = 1; i <= 4; i++) begin
            press_digit(4'(i));
            fail_seen |= pin_fail;
        end
        checks++; if (digits_entered !== 4'd4) begin errors++; $display("FAIL correct_digits: got %0d expected 4", digits_entered); end
        press_enter();
        checks++; if (pin_ok !== 1'b0) begin errors++; $display("FAIL correct_latency_early: got pin_ok %0b expected 0", pin_ok); end
        step();
        fail_seen |= pin_fail;
        checks++; if (pin_ok !== 1'b1) begin errors++; $display("FAIL correct_pin_ok: got %0b expected 1", pin_ok); end
        checks++; if (tries_left !== 3'd3) begin errors++; $display("FAIL correct_tries: got %0d expected 3", tries_left); end
        step();
        fail_seen |= pin_fail;
        checks++; if (fail_seen !== 1'b0) begin errors++; $display("FAIL correct_no_fail: got %0b expected 0", fail_seen); end
        card = 1'b0; step();
        checks++; if (pin_ok !== 1'b0) begin errors++; $display("FAIL correct_card_out: got %0b expected 0", pin_ok); end
        checks++; if ({pin_ok, pin_fail, card_retain, tries_left, digits_entered} !== model_vec())
            begin errors++; $display("FAIL correct_model: got %0h expected %0h",
                {pin_ok, pin_fail, card_retain, tries_left, digits_entered}, model_vec()); end
    endtask

    task automatic test_wrong_then_correct();
        logic [3:0] bad [4] = '{4'd1, 4'd2, 4'd3, 4'd5};
        card = 1'b1; step();
        foreach (bad[i]) press_digit(bad[i]);
        press_enter();
        step();
        checks++; if (pin_fail !== 1'b1) begin errors++; $display("FAIL wrong_pulse: got %0b expected 1", pin_fail); end
        checks++; if (tries_left !== 3'd2) begin errors++; $display("FAIL wrong_tries: got %0d expected 2", tries_left); end
        checks++; if (digits_entered !== 4'd0) begin errors++; $display("FAIL wrong_digits: got %0d expected 0", digits_entered); end
        step();
        checks++; if (pin_fail !== 1'b0) begin errors++; $display("FAIL wrong_pulse_width: got %0b expected 0", pin_fail); end
        for (int i = 1; i <= 4; i++) press_digit(4'(i));
        press_enter();
        step();
        checks++; if (pin_ok !== 1'b1) begin errors++; $display("FAIL retry_pin_ok: got %0b expected 1", pin_ok); end
        checks++; if (tries_left !== 3'd2) begin errors++; $display("FAIL retry_tries: got %0d expected 2", tries_left); end
        card = 1'b0; step();
    endtask

    task automatic test_lockout();
        card = 1'b1; step();
        for (int a = 0; a < 3; a++) begin
            for (int i = 0; i < 4; i++) press_digit(4'd9);
            press_enter();
            step();
        end
        checks++; if (card_retain !== 1'b1) begin errors++; $display("FAIL lock_retain: got %0b expected 1", card_retain); end
        checks++; if (tries_left !== 3'd0) begin errors++; $display("FAIL lock_tries: got %0d expected 0", tries_left); end
        for (int c = 0; c < 30; c++) begin
            card = 1'($urandom_range(0, 1)); digit_valid = 1'($urandom_range(0, 1));
            digit = 4'($urandom_range(0, 15)); enter = 1'($urandom_range(0, 1));
            cancel = 1'($urandom_range(0, 1));
            step();
            checks++;
            if ({pin_ok, pin_fail, card_retain, tries_left, digits_entered} !== {1'b0, 1'b0, 1'b1, 3'd0, 4'd0})
                begin errors++; $display("FAIL lock_hold: got ok=%0b fail=%0b retain=%0b tries=%0d digits=%0d",
                    pin_ok, pin_fail, card_retain, tries_left, digits_entered); end
        end
        digit_valid = 1'b0; enter = 1'b0; cancel = 1'b0; card = 1'b0;
        reset = 1'b0; step(); reset = 1'b1;
        checks++;
        if ({pin_ok, pin_fail, card_retain, tries_left, digits_entered} !== {1'b0, 1'b0, 1'b0, 3'd3, 4'd0})
            begin errors++; $display("FAIL lock_reset: got ok=%0b fail=%0b retain=%0b tries=%0d digits=%0d",
                pin_ok, pin_fail, card_retain, tries_left, digits_entered); end
    endtask

    task automatic test_filtering();
        card = 1'b1; step();
        press_digit(4'hA);
        checks++; if (digits_entered !== 4'd0) begin errors++; $display("FAIL filter_non_bcd: got %0d expected 0", digits_entered); end
        for (int i = 1; i <= 3; i++) press_digit(4'(i));
        press_enter();
        checks++; if (digits_entered !== 4'd3) begin errors++; $display("FAIL filter_short_enter: got %0d expected 3", digits_entered); end
        checks++; if (tries_left !== 3'd3) begin errors++; $display("FAIL filter_short_tries: got %0d expected 3", tries_left); end
        digit_valid = 1'b1; digit = 4'd4; enter = 1'b1;
        step();
        digit_valid = 1'b0; enter = 1'b0;
        checks++; if (digits_entered !== 4'd3) begin errors++; $display("FAIL filter_enter_wins: got %0d expected 3", digits_entered); end
        press_digit(4'd4);
        press_digit(4'd5);
        checks++; if (digits_entered !== 4'd4) begin errors++; $display("FAIL filter_fifth: got %0d expected 4", digits_entered); end
        digit_valid = 1'b1; digit = 4'd7; enter = 1'b1;
        step();
        digit_valid = 1'b0; enter = 1'b0;
        step();
        checks++; if (pin_ok !== 1'b1) begin errors++; $display("FAIL filter_full_submit: got %0b expected 1", pin_ok); end
        card = 1'b0; step();
    endtask

    task automatic test_timeout_cancel();
        card = 1'b1; step();
        for (int i = 0; i < 4; i++) press_digit(4'd0);
        press_enter(); step();
        press_digit(4'd1); press_digit(4'd2);
        for (int c = 0; c < TIMEOUT_CYCLES - 1; c++) step();
        checks++; if (digits_entered !== 4'd2) begin errors++; $display("FAIL timeout_early: got %0d expected 2", digits_entered); end
        step();
        checks++; if (digits_entered !== 4'd0) begin errors++; $display("FAIL timeout_expire: got %0d expected 0", digits_entered); end
        press_digit(4'd7);
        checks++; if (digits_entered !== 4'd0) begin errors++; $display("FAIL timeout_idle: got %0d expected 0", digits_entered); end
        card = 1'b0; step();
        card = 1'b1; step();
        checks++; if (tries_left !== 3'd3) begin errors++; $display("FAIL reinsert_tries: got %0d expected 3", tries_left); end
        press_digit(4'd1); press_digit(4'd2);
        cancel = 1'b1; step(); cancel = 1'b0;
        checks++; if (digits_entered !== 4'd0) begin errors++; $display("FAIL cancel_clear: got %0d expected 0", digits_entered); end
        checks++; if ({pin_ok, pin_fail, card_retain, tries_left, digits_entered} !== model_vec())
            begin errors++; $display("FAIL cancel_model: got %0h expected %0h",
                {pin_ok, pin_fail, card_retain, tries_left, digits_entered}, model_vec()); end
        card = 1'b0; step();
    endtask

    task automatic test_reset_mid();
        card = 1'b1; step();
        for (int i = 1; i <= 4; i++) press_digit(4'(i));
        press_enter();
        reset = 1'b0; step(); reset = 1'b1;
        checks++; if ({pin_ok, pin_fail, tries_left, digits_entered} !== {1'b0, 1'b0, 3'd3, 4'd0})
            begin errors++; $display("FAIL reset_in_check: got ok=%0b fail=%0b tries=%0d digits=%0d",
                pin_ok, pin_fail, tries_left, digits_entered); end
        press_digit(4'd1);
        checks++; if (digits_entered !== 4'd0) begin errors++; $display("FAIL reset_check_idle: got %0d expected 0", digits_entered); end
        for (int i = 1; i <= 4; i++) press_digit(4'(i));
        press_enter(); step();
        checks++; if (pin_ok !== 1'b1) begin errors++; $display("FAIL reset_auth_setup: got %0b expected 1", pin_ok); end
        reset = 1'b0; step(); reset = 1'b1;
        checks++; if ({pin_ok, pin_fail, digits_entered} !== {1'b0, 1'b0, 4'd0})
            begin errors++; $display("FAIL reset_in_auth: got ok=%0b fail=%0b digits=%0d", pin_ok, pin_fail, digits_entered); end
        card = 1'b0; step();
    endtask

    task automatic test_random();
        logic [15:0] pin;
        int          k;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 299) == 0 || c == 0) begin
                pin = '0;
                for (int i = 0; i < 4; i++) pin = (pin << 4) | 16'($urandom_range(0, 9));
                stored_pin = pin;
            end
            reset       = ($urandom_range(0, 249) != 0);
            card        = ($urandom_range(0, 49) != 0);
            cancel      = ($urandom_range(0, 59) == 0);
            enter       = ($urandom_range(0, 5) == 0);
            digit_valid = ($urandom_range(0, 2) != 0);
            k = m_typed.size();
            if (k < 4 && $urandom_range(0, 2) != 0) digit = stored_pin[4*(3-k) +: 4];
            else if ($urandom_range(0, 9) == 0)      digit = 4'($urandom_range(10, 15));
            else                                     digit = 4'($urandom_range(0, 9));
            step();
            checks++;
            if ({pin_ok, pin_fail, card_retain, tries_left, digits_entered} !== model_vec())
                begin errors++; $display("FAIL random_cycle_%0d: got %0h expected %0h", c,
                    {pin_ok, pin_fail, card_retain, tries_left, digits_entered}, model_vec()); end
        end
        reset = 1'b1; card = 1'b0; cancel = 1'b0; enter = 1'b0; digit_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_correct_pin();
        test_wrong_then_correct();
        test_lockout();
        test_filtering();
        test_timeout_cancel();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
